// File: rtl/traffic_pkg.sv
// Shared definitions between the presence conditioner and the light controller:
// lane indices, controller state codes, light colours and the green-lane decode.
package traffic_pkg;

  localparam int unsigned NUM_LANES = 8;
  localparam int unsigned STATE_W   = 5;
  localparam int unsigned DEB_W     = 4;
  localparam int unsigned STUCK_W   = 16;

  localparam int unsigned LANE_N  = 0;
  localparam int unsigned LANE_S  = 1;
  localparam int unsigned LANE_E  = 2;
  localparam int unsigned LANE_W  = 3;
  localparam int unsigned LANE_NL = 4;
  localparam int unsigned LANE_SL = 5;
  localparam int unsigned LANE_EL = 6;
  localparam int unsigned LANE_WL = 7;

  typedef enum logic [STATE_W-1:0] {
    n_s     = 5'd0,
    e_w     = 5'd1,
    n_s_y   = 5'd2,
    e_w_y   = 5'd3,
    n_nl    = 5'd4,
    n_nl_y  = 5'd5,
    s_sl    = 5'd6,
    s_sl_y  = 5'd7,
    w_wl    = 5'd8,
    w_wl_y  = 5'd9,
    e_el    = 5'd10,
    e_el_y  = 5'd11,
    nl_sl   = 5'd12,
    nl_sl_y = 5'd13,
    el_wl   = 5'd14,
    el_wl_y = 5'd15
  } ctl_state_e;

  typedef enum logic [1:0] {
    LIGHT_R = 2'd0,
    LIGHT_Y = 2'd1,
    LIGHT_G = 2'd2
  } light_e;

  // Lanes shown green for a controller state; yellow and unused codes serve nobody.
  function automatic logic [NUM_LANES-1:0] lane_green_mask(input logic [STATE_W-1:0] state);
    logic [NUM_LANES-1:0] mask;
    mask = '0;
    case (state)
      n_s: begin
        mask[LANE_N] = 1'b1;
        mask[LANE_S] = 1'b1;
      end
      e_w: begin
        mask[LANE_E] = 1'b1;
        mask[LANE_W] = 1'b1;
      end
      n_nl: begin
        mask[LANE_N]  = 1'b1;
        mask[LANE_NL] = 1'b1;
      end
      s_sl: begin
        mask[LANE_S]  = 1'b1;
        mask[LANE_SL] = 1'b1;
      end
      w_wl: begin
        mask[LANE_W]  = 1'b1;
        mask[LANE_WL] = 1'b1;
      end
      e_el: begin
        mask[LANE_E]  = 1'b1;
        mask[LANE_EL] = 1'b1;
      end
      nl_sl: begin
        mask[LANE_NL] = 1'b1;
        mask[LANE_SL] = 1'b1;
      end
      el_wl: begin
        mask[LANE_EL] = 1'b1;
        mask[LANE_WL] = 1'b1;
      end
      default: mask = '0;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/presence_lane.sv
// One detector lane: synchronizer, debounce filter, call latch served by green,
// and a stuck-on monitor whose sticky fault forces a permanent recall.
module presence_lane
  import traffic_pkg::*;
#(
  parameter int unsigned DEB_CYCLES   = 4,
  parameter int unsigned STUCK_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  input  logic green_i,
  output logic presence_o,
  output logic fault_o
);

  localparam logic [DEB_W-1:0]   DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
  localparam logic [STUCK_W-1:0] STUCK_MAX = STUCK_W'(STUCK_CYCLES);

  logic [1:0]         sync_q, sync_d;
  logic               filt_q, filt_d;
  logic               filt_dly_q, filt_dly_d;
  logic [DEB_W-1:0]   deb_cnt_q, deb_cnt_d;
  logic [STUCK_W-1:0] stuck_cnt_q, stuck_cnt_d;
  logic               call_q, call_d;
  logic               fault_q, fault_d;
  logic               s2;

  assign s2 = sync_q[1];

  // Next-state for all lane registers.
  always_comb begin
    sync_d      = {sync_q[0], raw_i};
    filt_d      = filt_q;
    filt_dly_d  = filt_q;
    deb_cnt_d   = '0;
    stuck_cnt_d = '0;
    call_d      = call_q;
    fault_d     = fault_q;

    if (s2 != filt_q) begin
      if (deb_cnt_q == DEB_LAST) begin
        filt_d = s2;
      end else begin
        deb_cnt_d = deb_cnt_q + DEB_W'(1);
      end
    end

    // Set wins over serve so a fresh arrival is never lost.
    if (green_i && !filt_q) begin
      call_d = 1'b0;
    end
    if (filt_q && !filt_dly_q) begin
      call_d = 1'b1;
    end

    if (filt_q) begin
      if (stuck_cnt_q == STUCK_MAX) begin
        stuck_cnt_d = stuck_cnt_q;
      end else begin
        stuck_cnt_d = stuck_cnt_q + STUCK_W'(1);
      end
      if (stuck_cnt_d == STUCK_MAX) begin
        fault_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q      <= '0;
      filt_q      <= 1'b0;
      filt_dly_q  <= 1'b0;
      deb_cnt_q   <= '0;
      stuck_cnt_q <= '0;
      call_q      <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      filt_q      <= filt_d;
      filt_dly_q  <= filt_dly_d;
      deb_cnt_q   <= deb_cnt_d;
      stuck_cnt_q <= stuck_cnt_d;
      call_q      <= call_d;
      fault_q     <= fault_d;
    end
  end

  // A faulty detector holds presence so its lane is never starved.
  assign presence_o = filt_q | call_q | fault_q;
  assign fault_o    = fault_q;

endmodule

// File: rtl/presence_conditioner.sv
// Conditions eight raw loop detectors into controller presence inputs, clearing
// each latched call when the controller reports that lane green.
module presence_conditioner
  import traffic_pkg::*;
#(
  parameter int unsigned DEB_CYCLES   = 4,
  parameter int unsigned STUCK_CYCLES = 1024
) (
  input  logic                 CLK,
  input  logic                 rst_n,
  input  logic [NUM_LANES-1:0] raw_det,
  input  logic [STATE_W-1:0]   ctl_state,
  output logic [NUM_LANES-1:0] presence,
  output logic [NUM_LANES-1:0] fault,
  output logic                 fault_any
);

  logic [NUM_LANES-1:0] green_c;

  assign green_c = lane_green_mask(ctl_state);

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    presence_lane #(
      .DEB_CYCLES  (DEB_CYCLES),
      .STUCK_CYCLES(STUCK_CYCLES)
    ) u_lane (
      .clk       (CLK),
      .rst_n     (rst_n),
      .raw_i     (raw_det[i]),
      .green_i   (green_c[i]),
      .presence_o(presence[i]),
      .fault_o   (fault[i])
    );
  end

  assign fault_any = |fault;

endmodule
